// File: rtl/conv_filter_acc.sv
// conv_filter_acc: time-multiplexed convolution filter with valid/ready on both sides.
// Each beat carries LANES channels of a TAPS-point window plus signed weights. The lane
// products are summed over NCH/LANES beats on top of a per-pixel bias. The total is then
// arithmetically shifted right by SHIFT and saturated to OUT_W bits.
// Optional feature: define CONV_FILTER_ACC_RELU_EN to clamp negative results to zero.
module conv_filter_acc #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned LANES = 3,
    parameter int unsigned TAPS  = 9,
    parameter int unsigned A_W   = 6,
    parameter int unsigned W_W   = 8,
    parameter int unsigned B_W   = 16,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned OUT_W = 13
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*TAPS*A_W-1:0]     act,
    input  logic [LANES*TAPS*W_W-1:0]     wgt,
    input  logic [B_W-1:0]                bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out
);

    localparam int unsigned BEATS = NCH / LANES;
    localparam int unsigned ACC_W = A_W + W_W + $clog2(TAPS * NCH) + 2;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned P_W   = A_W + W_W + 1;
    localparam int unsigned NPROD = LANES * TAPS;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    en;
    logic                    first_beat;
    logic                    last_beat;
    logic [CNT_W-1:0]        beat_cnt;
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [A_W:0]     a_s;
    logic signed [W_W-1:0]   w_s;
    logic signed [P_W-1:0]   prod;

    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [ACC_W-1:0] s1_sum;
    logic [B_W-1:0]          s1_bias;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] res;

    // Every stage advances together; a pending unconsumed result freezes the whole pipe.
    assign en         = !abort && (!out_valid || out_ready);
    assign in_ready   = en;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));

    // Sum of all lane/tap products of the current beat; activations are zero-extended.
    always_comb begin
        lane_sum = '0;
        a_s      = '0;
        w_s      = '0;
        prod     = '0;
        for (int i = 0; i < NPROD; i++) begin
            a_s      = $signed({1'b0, act[i*A_W +: A_W]});
            w_s      = $signed(wgt[i*W_W +: W_W]);
            prod     = a_s * w_s;
            lane_sum = lane_sum + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        end
    end

    // Stage 1: register the beat sum and its position within the pixel.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            beat_cnt <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            s1_bias  <= '0;
        end else if (abort) begin
            beat_cnt <= '0;
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sum   <= lane_sum;
            s1_first <= first_beat;
            s1_last  <= last_beat;
            if (in_valid && first_beat) begin
                s1_bias <= bias;
            end
            if (in_valid) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // Accumulate on top of the bias for the first beat, then shift, saturate and clamp.
    always_comb begin
        acc_base = s1_first ? {{(ACC_W-B_W){s1_bias[B_W-1]}}, s1_bias} : acc;
        acc_next = acc_base + s1_sum;
        shifted  = acc_next >>> SHIFT;
        if (shifted > OUT_MAX) begin
            res = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            res = OUT_MIN[OUT_W-1:0];
        end else begin
            res = shifted[OUT_W-1:0];
        end
`ifdef CONV_FILTER_ACC_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
        end
`endif
    end

    // Stage 2: accumulator and output register; a new result takes priority over consumption.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (abort) begin
                acc <= '0;
            end else if (en && s1_valid) begin
                acc <= acc_next;
            end
            if (en && s1_valid && s1_last) begin
                out       <= res;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv_filter_acc.md
# conv_filter_acc

Parametrised, time-multiplexed convolution filter: each accepted beat carries LANES input channels of one TAPS-point window plus matching signed weights; the block sums the lane products over NCH/LANES beats, adds a per-output bias, applies an arithmetic right shift and saturation, and presents one OUT_W result per output pixel. It replaces the fixed 3-channel single-cycle filter in the conv-layer datapath. Valid/ready handshakes on both sides let it sit between the line-buffer/weight fetch and the feature-map writer with back-pressure.

## Interface
- NCH, 6: input channels per output; must be a multiple of LANES
- LANES, 3: channels processed per beat
- TAPS, 9: kernel points per channel
- A_W, 6: activation width, unsigned
- W_W, 8: weight width, signed
- B_W, 16: bias width, signed
- SHIFT, 7: arithmetic right shift applied to the final sum
- OUT_W, 13: result width, signed, saturated
- Derived: BEATS = NCH/LANES; ACC_W = A_W+W_W+$clog2(TAPS*NCH)+2 (wide enough to hold the bias too)
- CLK  in  1  clock
- CLR  in  1  asynchronous active-high reset
- abort  in  1  synchronous; discards partial accumulation
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- act  in  LANES*TAPS*A_W  lane l, tap t at [(l*TAPS+t)*A_W +: A_W]
- wgt  in  LANES*TAPS*W_W  same packing with W_W
- bias  in  B_W  sampled only on the first beat of a pixel
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out  out  OUT_W  signed result

## Operation
- Global enable: en = !abort && (!out_valid || out_ready); in_ready = en.
- Stage 1 (on en): register the lane sum S = sum over lanes and taps of $signed({1'b0,act}) * $signed(wgt); s1_valid <= accepted beat; s1_last <= (beat_cnt == BEATS-1); s1_first <= (beat_cnt == 0); s1_bias <= bias when first.
- beat_cnt increments on each accepted beat and wraps to 0 after BEATS-1. When BEATS == 1, every beat is both first and last.
- Stage 2 (on en and s1_valid): acc <= (s1_first ? sext(s1_bias) : acc) + sext(S).
- On s1_last: r = (acc_next >>> SHIFT), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. r is loaded into out and out_valid <= 1 in the same cycle.
- out_valid clears on out_ready, unless a new result loads in that same cycle, in which case it stays 1 and out takes the new value.
- abort: clears beat_cnt, s1_valid and acc. It does not touch out or out_valid. In_ready is low during abort, so no beat is accepted that cycle.
- Shift is arithmetic, rounding toward −inf (e.g. −1 >>> 7 = −1).

## Timing
- Reset values: out = 0, out_valid = 0, in_ready = 1 (after CLR deasserts); beat_cnt, acc and s1_valid are all 0.
- Latency: out_valid rises 2 cycles after the last beat of a pixel is accepted.
- Throughput: 1 beat per cycle, i.e. 1 result per BEATS cycles, with no bubbles while out_ready = 1.
- Stall: while out_valid && !out_ready, all stages freeze and out stays stable.
- CLR asserted mid-pixel: all state returns to reset values immediately and the partial sum is lost.

## Configuration
- CONV_FILTER_ACC_RELU_EN defined: after the shift and saturate, negative results become 0, so out is in [0, 2^(OUT_W-1)-1].
- Not defined: the signed saturated result passes through unchanged.

## Test plan
- Defaults, act = 2 and wgt = 3 on all taps, bias = 60, 2 beats: 324 + 60 = 384, so out = 3 two cycles after the 2nd beat.
- Defaults, act = 63, wgt = 127 everywhere, bias = 0: out = 3375. Rerun with SHIFT = 5: out = 4095 (saturated).
- Defaults, act = 63, wgt = −128, SHIFT = 5: out = −4096. With CONV_FILTER_ACC_RELU_EN: out = 0. Separately, act = 0, bias = −1: out = −1 without the macro.
- Back-pressure: hold out_ready = 0 for 5 cycles while streaming 3 pixels. Out holds the first result, in_ready drops, and no beats or results are lost or duplicated.
- Abort after beat 1 of a pixel, then stream a fresh 2-beat pixel: the result equals that pixel alone, and the pending out is unaffected.
- CLR asserted asynchronously mid-pixel: out = 0 and out_valid = 0 immediately; the next pixel is computed correctly.
